// File: rtl/rx_serial_7e1_if.sv
// Signal bundle between the 7E1 serial receiver and its consumer.
// The master side is the receiver; the slave side drives the line and the acknowledge.
interface rx_serial_7e1_if;
    logic       dado_serial;
    logic       recebe_dado;
    logic [6:0] dados_ascii;
    logic       paridade_ok;
    logic       erro_quadro;
    logic       pronto;
    logic       tem_dado;
    logic [3:0] db_estado;

    modport master (
        input  dado_serial,
        input  recebe_dado,
        output dados_ascii,
        output paridade_ok,
        output erro_quadro,
        output pronto,
        output tem_dado,
        output db_estado
    );

    modport slave (
        output dado_serial,
        output recebe_dado,
        input  dados_ascii,
        input  paridade_ok,
        input  erro_quadro,
        input  pronto,
        input  tem_dado,
        input  db_estado
    );
endinterface

// File: rtl/rx_serial_7e1.sv
// Asynchronous serial receiver, 7 data bits + even parity + 1 stop (7E1).
// Samples each bit mid-period using a modulo-M bit timer after a verified start bit.
module rx_serial_7e1 #(
    parameter int M = 434,
    parameter int N = 9
) (
    input  logic          clock,
    input  logic          reset,
    rx_serial_7e1_if.master bus
);

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        ESPERA_START = 4'd1,
        MEIO_START   = 4'd2,
        ESPERA_BIT   = 4'd3,
        AMOSTRA      = 4'd4,
        ARMAZENA     = 4'd5,
        FINAL        = 4'd6
    } state_t;

    localparam logic [N-1:0] TIMER_LAST = N'(M - 1);
    localparam logic [N-1:0] HALF_LAST  = N'(M / 2 - 1);

    state_t       state, state_next;
    logic         sync_a, rx;
    logic [N-1:0] timer;
    logic         zera_s, conta, fim;
    logic [3:0]   bit_cnt;
    logic         zera_c, inc_c;
    logic         shift, store;
    logic [8:0]   shreg;
    logic [6:0]   dados_q;
    logic         paridade_q, erro_q, tem_q;

    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a <= 1'b1;
            rx     <= 1'b1;
        end else begin
            sync_a <= bus.dado_serial;
            rx     <= sync_a;
        end
    end

    // Bit timer: clear has priority, counting wraps from M-1 back to 0.
    assign fim = (timer == TIMER_LAST);

    always_ff @(posedge clock) begin
        if (reset || zera_s) begin
            timer <= '0;
        end else if (conta) begin
            timer <= fim ? '0 : timer + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || zera_c) begin
            bit_cnt <= '0;
        end else if (inc_c) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg <= '0;
        end else if (shift) begin
            shreg <= {rx, shreg[8:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= INICIAL;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal gets a default before the case so no latch can be inferred.
    always_comb begin
        state_next = state;
        zera_s     = 1'b0;
        conta      = 1'b0;
        zera_c     = 1'b0;
        inc_c      = 1'b0;
        shift      = 1'b0;
        store      = 1'b0;
        unique case (state)
            INICIAL: begin
                zera_s     = 1'b1;
                zera_c     = 1'b1;
                state_next = ESPERA_START;
            end
            ESPERA_START: begin
                zera_s = 1'b1;
                zera_c = 1'b1;
                if (!rx) state_next = MEIO_START;
            end
            MEIO_START: begin
                conta = 1'b1;
                if (timer == HALF_LAST) begin
                    zera_s     = 1'b1;
                    state_next = rx ? ESPERA_START : ESPERA_BIT;
                end
            end
            ESPERA_BIT: begin
                conta = 1'b1;
                if (fim) state_next = AMOSTRA;
            end
            AMOSTRA: begin
                // Keep the timer running so consecutive samples stay exactly M apart.
                conta      = 1'b1;
                shift      = 1'b1;
                inc_c      = 1'b1;
                state_next = (bit_cnt == 4'd8) ? ARMAZENA : ESPERA_BIT;
            end
            ARMAZENA: begin
                store      = 1'b1;
                state_next = FINAL;
            end
            FINAL: begin
                state_next = ESPERA_START;
            end
            default: begin
                state_next = INICIAL;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dados_q    <= '0;
            paridade_q <= 1'b0;
            erro_q     <= 1'b0;
            tem_q      <= 1'b0;
        end else begin
            if (store) begin
                dados_q    <= shreg[6:0];
                paridade_q <= ~(^shreg[7:0]);
                erro_q     <= ~shreg[8];
            end
            if (store) begin
                tem_q <= 1'b1;
            end else if (bus.recebe_dado) begin
                tem_q <= 1'b0;
            end
        end
    end

    assign bus.dados_ascii = dados_q;
    assign bus.paridade_ok = paridade_q;
    assign bus.erro_quadro = erro_q;
    assign bus.tem_dado    = tem_q;
    assign bus.pronto      = (state == FINAL);
    assign bus.db_estado   = state;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Self-checking bench for rx_serial_7e1: directed 7E1 scenarios plus random frames
// compared against a frame-level reference model.
module tb_rx_serial_7e1;

    localparam int M = 434;
    localparam int N = 9;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    rx_serial_7e1_if bus ();

    rx_serial_7e1 #(.M(M), .N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    int   pronto_cnt  = 0;
    int   pronto_wide = 0;
    logic prev_pronto = 1'b0;
    logic watch_tem   = 1'b0;
    int   tem_drops   = 0;

    logic       ack_pending   = 1'b0;
    logic       tem_at_pronto = 1'b0;

    logic [6:0] exp_dados;
    logic       exp_par, exp_erro;

    always @(negedge clock) begin
        if (bus.pronto === 1'b1) begin
            pronto_cnt++;
            if (prev_pronto) pronto_wide++;
        end
        prev_pronto = (bus.pronto === 1'b1);
        if (watch_tem && bus.tem_dado !== 1'b1) tem_drops++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of line time; also releases a held acknowledge on the pronto cycle.
    task automatic tick();
        @(negedge clock);
        if (ack_pending && bus.pronto === 1'b1) begin
            tem_at_pronto   = bus.tem_dado;
            bus.recebe_dado = 1'b0;
            ack_pending     = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        bus.dado_serial = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [6:0] c, input logic p, input logic s);
        logic [8:0] bits;
        bits = {s, p, c};
        bus.dado_serial = 1'b0;
        repeat (M) tick();
        for (int i = 0; i < 9; i++) begin
            bus.dado_serial = bits[i];
            repeat (M) tick();
        end
        bus.dado_serial = 1'b1;
    endtask

    // Reference model: what the receiver must hold after a complete frame.
    task automatic model_frame(input logic [6:0] c, input logic p, input logic s);
        exp_dados = c;
        exp_par   = ~((^c) ^ p);
        exp_erro  = ~s;
    endtask

    task automatic check_held(input string tag, input logic exp_tem);
        check({tag, ".dados"}, 32'(bus.dados_ascii), 32'(exp_dados));
        check({tag, ".par"},   32'(bus.paridade_ok), 32'(exp_par));
        check({tag, ".erro"},  32'(bus.erro_quadro), 32'(exp_erro));
        check({tag, ".tem"},   32'(bus.tem_dado),    32'(exp_tem));
    endtask

    task automatic frame_and_check(input string tag, input logic [6:0] c, input logic p, input logic s);
        int p0;
        p0 = pronto_cnt;
        model_frame(c, p, s);
        send_frame(c, p, s);
        idle(s ? 4 : M + 10);
        check({tag, ".pronto"}, 32'(pronto_cnt - p0), 32'd1);
        check_held(tag, 1'b1);
    endtask

    initial begin
        int         p0;
        logic [6:0] c;
        logic       p, s;

        reset           = 1'b1;
        bus.dado_serial = 1'b1;
        bus.recebe_dado = 1'b0;
        repeat (3) tick();
        check("rst.estado", 32'(bus.db_estado),   32'd0);
        check("rst.dados",  32'(bus.dados_ascii), 32'd0);
        check("rst.par",    32'(bus.paridade_ok), 32'd0);
        check("rst.erro",   32'(bus.erro_quadro), 32'd0);
        check("rst.pronto", 32'(bus.pronto),      32'd0);
        check("rst.tem",    32'(bus.tem_dado),    32'd0);
        reset = 1'b0;
        idle(3);
        check("idle.estado", 32'(bus.db_estado), 32'd1);

        frame_and_check("A", 7'h41, ^7'h41, 1'b1);

        // Wrong parity, then acknowledge: data must survive the ack.
        frame_and_check("C_badpar", 7'h43, 1'b0, 1'b1);
        bus.recebe_dado = 1'b1;
        tick();
        bus.recebe_dado = 1'b0;
        tick();
        check("ack.tem",   32'(bus.tem_dado),    32'd0);
        check("ack.dados", 32'(bus.dados_ascii), 32'h43);
        check("ack.par",   32'(bus.paridade_ok), 32'd0);

        // Short low glitch is a false start.
        p0 = pronto_cnt;
        bus.dado_serial = 1'b0;
        repeat (100) tick();
        idle(M);
        check("glitch.pronto", 32'(pronto_cnt - p0), 32'd0);
        check("glitch.estado", 32'(bus.db_estado),   32'd1);
        check("glitch.tem",    32'(bus.tem_dado),    32'd0);
        frame_and_check("A_after_glitch", 7'h41, ^7'h41, 1'b1);

        // Framing error, then recovery on a clean frame.
        frame_and_check("A_stop0", 7'h41, ^7'h41, 1'b0);
        idle(M);
        frame_and_check("C_after_err", 7'h43, ^7'h43, 1'b1);

        // Reset in the middle of data bit 3.
        p0 = pronto_cnt;
        bus.dado_serial = 1'b0;
        repeat (M) tick();
        for (int i = 0; i < 3; i++) begin
            bus.dado_serial = i[0];
            repeat (M) tick();
        end
        bus.dado_serial = 1'b1;
        repeat (M / 2) tick();
        reset = 1'b1;
        repeat (2) tick();
        check("midrst.estado", 32'(bus.db_estado),   32'd0);
        check("midrst.dados",  32'(bus.dados_ascii), 32'd0);
        check("midrst.tem",    32'(bus.tem_dado),    32'd0);
        check("midrst.erro",   32'(bus.erro_quadro), 32'd0);
        reset = 1'b0;
        idle(2 * M);
        check("midrst.pronto", 32'(pronto_cnt - p0), 32'd0);
        frame_and_check("Z", 7'h5A, ^7'h5A, 1'b1);

        // Back-to-back frames with no acknowledge in between.
        p0 = pronto_cnt;
        watch_tem = 1'b1;
        model_frame(7'h69, ^7'h69, 1'b1);
        send_frame(7'h48, ^7'h48, 1'b1);
        send_frame(7'h69, ^7'h69, 1'b1);
        idle(4);
        watch_tem = 1'b0;
        check("b2b.pronto", 32'(pronto_cnt - p0), 32'd2);
        check("b2b.drops",  32'(tem_drops),       32'd0);
        check_held("b2b", 1'b1);

        // Acknowledge held through the store cycle: set must win.
        bus.recebe_dado = 1'b1;
        ack_pending     = 1'b1;
        frame_and_check("setwins", 7'h2B, ^7'h2B, 1'b1);
        check("setwins.at_pronto", 32'(tem_at_pronto), 32'd1);
        bus.recebe_dado = 1'b1;
        tick();
        bus.recebe_dado = 1'b0;
        tick();
        check("setwins.ack", 32'(bus.tem_dado), 32'd0);

        for (int k = 0; k < 3; k++) begin
            c = 7'($urandom_range(0, 127));
            p = (^c) ^ ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 3) != 0);
            frame_and_check($sformatf("rand%0d", k), c, p, s);
        end

        check("pronto.width", 32'(pronto_wide), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
